// File: rtl/cv32e40px_event_log_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40px_event_log_pkg
//   Shared types and constants for the instruction event log.
//   - EV_* : channel indices of the architectural event strobes.
//   - entry_t : one captured FIFO entry {channel, PC, cycle timestamp}.
//   The channel field is sized for the largest supported channel count (8);
//   the top level narrows it to its own rd_ch_o width.
// ----------------------------------------------------------------------------
package cv32e40px_event_log_pkg;

  localparam int unsigned EV_ILLEGAL = 0;
  localparam int unsigned EV_ECALL   = 1;
  localparam int unsigned EV_EBREAK  = 2;
  localparam int unsigned EV_WFI     = 3;

  localparam int unsigned CH_MAX_W = 3;

  typedef struct packed {
    logic [CH_MAX_W-1:0] ch;
    logic [31:0]         pc;
    logic [31:0]         ts;
  } entry_t;

endpackage

// File: rtl/cv32e40px_event_fifo.sv
// ----------------------------------------------------------------------------
// cv32e40px_event_fifo
//   Capture FIFO for the event log. Pointers carry one extra MSB so full and
//   empty are distinguished without a separate counter.
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     flush_i         synchronous empty; wins over push and pop
//     push_i          write push_data_i (accepted if not full, or if full
//                     with a same-cycle pop)
//     pop_i           consumer ready; pops only when not empty
//     head_o          entry at the head (valid while empty_o = 0)
//     full_o/empty_o  occupancy flags
//     level_o         number of stored entries
//     drop_o          push rejected this cycle (full and no pop)
// ----------------------------------------------------------------------------
module cv32e40px_event_fifo
  import cv32e40px_event_log_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        push_i,
  input  entry_t      push_data_i,
  input  logic        pop_i,
  output entry_t      head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] level_o,
  output logic        drop_o
);

  entry_t      mem [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        pop_ok;
  logic        push_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign pop_ok  = pop_i & ~empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & full_o & ~pop_ok;

  // NOTE: non-blocking assignments in every clocked block so all state
  // updates see the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide what is valid,
  // which keeps the array mappable onto plain flops or RAM.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  // Head is read from storage only, so a same-cycle push into an empty FIFO
  // becomes visible one cycle later and is never forwarded.
  assign head_o = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/cv32e40px_insn_event_log.sv
// ----------------------------------------------------------------------------
// cv32e40px_insn_event_log
//   Counts per-channel instruction events seen in ID and captures one
//   {channel, PC, timestamp} entry per cycle with any event into a FIFO.
//   Ports:
//     clk_i, rst_ni          clock, asynchronous active-low reset
//     clear_i                synchronous clear of counters, FIFO, overflow
//     is_decoding_i          ID holds a valid decoding instruction
//     ev_i[NUM_CH]           event strobes (bit 0 = illegal instruction)
//     pc_id_i, hart_id_i     PC in ID; hart id (display only)
//     rd_valid_o/rd_ready_i  FIFO head handshake
//     rd_ch_o/pc_o/ts_o      head entry fields
//     cnt_o                  packed saturating counters, ch k at [k*CNT_W +: CNT_W]
//     level_o                FIFO occupancy
//     overflow_o             sticky: an entry was dropped
//   Configuration: define CV32E40PX_EVENT_LOG_DISPLAY_EN for simulation
//   messages on illegal instructions and dropped entries.
// ----------------------------------------------------------------------------
module cv32e40px_insn_event_log
  import cv32e40px_event_log_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned CNT_W  = 16,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    is_decoding_i,
  input  logic [NUM_CH-1:0]       ev_i,
  input  logic [31:0]             pc_id_i,
  input  logic [31:0]             hart_id_i,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  output logic [CH_W-1:0]         rd_ch_o,
  output logic [31:0]             rd_pc_o,
  output logic [31:0]             rd_ts_o,
  output logic [NUM_CH*CNT_W-1:0] cnt_o,
  output logic [LVL_W-1:0]        level_o,
  output logic                    overflow_o
);

  logic [NUM_CH-1:0]   qual;
  logic                any_qual;
  logic [CH_MAX_W-1:0] first_ch;
  logic [CNT_W-1:0]    cnt_q [NUM_CH];
  logic [31:0]         ts_q;
  logic                overflow_q;
  entry_t              push_entry;
  entry_t              head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                drop;

  assign qual     = ev_i & {NUM_CH{is_decoding_i}};
  assign any_qual = |qual;

  // Scan from the top so the lowest qualified channel is the one that sticks.
  // NOTE: a combinational block assigns its output a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    first_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (qual[k]) first_ch = CH_MAX_W'(k);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (qual[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt_out
    assign cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
  end

  // Free-running timestamp; clear_i deliberately leaves it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_q <= '0;
    else         ts_q <= ts_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      overflow_q <= 1'b0;
    else if (clear_i) overflow_q <= 1'b0;
    else if (drop)    overflow_q <= 1'b1;
  end

  assign push_entry.ch = first_ch;
  assign push_entry.pc = pc_id_i;
  assign push_entry.ts = ts_q;

  cv32e40px_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (clear_i),
    .push_i      (any_qual),
    .push_data_i (push_entry),
    .pop_i       (rd_ready_i),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level_o),
    .drop_o      (drop)
  );

  assign rd_valid_o = ~fifo_empty;
  assign rd_ch_o    = head.ch[CH_W-1:0];
  assign rd_pc_o    = head.pc;
  assign rd_ts_o    = head.ts;
  assign overflow_o = overflow_q;

  // Bits that only matter in some configurations (display id, wide channel
  // field, full flag used through drop_o).
  logic unused_bits;
  assign unused_bits = ^{hart_id_i, head.ch, fifo_full};

`ifdef CV32E40PX_EVENT_LOG_DISPLAY_EN
  always @(negedge clk_i) begin
    if (rst_ni && qual[EV_ILLEGAL])
      $display("%t: Illegal instruction (core %0d) at PC 0x%h:",
               $time, hart_id_i[3:0], pc_id_i);
    if (rst_ni && !clear_i && drop)
      $display("%t: event log overflow (core %0d), entry at PC 0x%h dropped",
               $time, hart_id_i[3:0], pc_id_i);
  end
`else
`endif

endmodule
